mem_wb_pipe: RTL and testbench
==============================

# mem_wb_pipe

Parametrised MEM→WB pipeline register for the CPU datapath. It carries the write-back control field, N data words and the destination register index from the memory stage to the write-back stage through DEPTH chained register slices. Beyond plain registering, it adds synchronous reset, stall (hold), flush (bubble insertion), a valid bit per slice, suppression of writes to register 0, and a saturating bubble counter for performance debug.

## Interface
- DATA_W, 32: width of each data word.
- NUM_DATA, 2: number of data words carried. Word 0 is the ALU result; word 1 is the memory read data. Must be ≥1.
- REG_W, 5: destination register index width.
- CTRL_W, 2: WB control field width, ≥2. Bit 1 is reg_write; bit 0 is mem_to_reg; bits above pass through.
- DEPTH, 1: number of chained register slices, ≥1.
- CNT_W, 16: bubble counter width.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- stall  in  1  hold all slices.
- flush  in  1  invalidate all slices.
- in_valid  in  1  input stage holds a real instruction.
- wb_in  in  CTRL_W  WB control field.
- data_in  in  NUM_DATA*DATA_W  packed data words; word k is at bits [k*DATA_W +: DATA_W].
- rd_in  in  REG_W  destination register.
- out_valid  out  1  valid bit of the last slice.
- ctrl_out  out  CTRL_W  control field of the last slice, with gating applied.
- reg_write  out  1  ctrl_out[1].
- mem_to_reg  out  1  ctrl_out[0].
- data_out  out  NUM_DATA*DATA_W  data words of the last slice.
- rd_out  out  REG_W  destination register of the last slice.
- bubble_cnt  out  CNT_W  saturating count of cycles with out_valid=0.

## Operation
- Each slice holds {valid, ctrl, data, rd}. Slice 0 captures the inputs; slice i captures slice i-1.
- Priority at each rising edge is rst > flush > stall > advance.
  - rst: every slice's fields go to 0, and bubble_cnt goes to 0.
  - flush: every slice's valid and ctrl go to 0. Data and rd are don't-care and are kept in place. bubble_cnt keeps counting.
  - stall: all slices hold their contents.
  - advance: all slices shift by one.
- Capture gating at slice 0:
  - If in_valid=0, the stored ctrl is 0.
  - If rd_in=0, the stored ctrl bit 1 (reg_write) is 0. The other ctrl bits, the data and rd are stored as given.
- Outputs are driven directly from the last slice. No combinational path exists from any input to any output.
- Invariant: reg_write=1 implies out_valid=1 and rd_out≠0.
- bubble_cnt increments at each edge where rst=0 and the pre-edge out_valid=0. It saturates at 2^CNT_W−1 and does not wrap.
- mem_to_reg is decoded only. Mux selection belongs to the WB stage, not to this block.

## Timing
- Latency is DEPTH cycles from input capture to output when there is no stall or flush. Throughput is one item per cycle.
- Reset values: out_valid=0, ctrl_out=0, reg_write=0, mem_to_reg=0, data_out=0, rd_out=0, bubble_cnt=0.
- After rst deasserts, out_valid stays 0 for at least DEPTH cycles.
- stall held for k cycles delays every slice by exactly k cycles. No item is lost or duplicated.
- flush and stall asserted in the same cycle: flush wins, and the pipeline is empty afterwards.
- flush and in_valid asserted in the same cycle: the input is discarded.
- rst asserted mid-stream: all in-flight items are discarded on that edge.
- bubble_cnt at saturation stays saturated until rst.

## Structure
- Shared package cpu_pkg holds:
  - WB control bit-position constants: WB_REG_WRITE=1, WB_MEM_TO_REG=0.
  - The default widths.
- Sub-module wb_pipe_slice is one register slice with valid, stall and flush inputs. mem_wb_pipe chains DEPTH instances of it with a generate loop. Capture gating and bubble_cnt live in the top module.

## Test plan
- Reset: assert rst for 2 cycles with the inputs driven non-zero → all outputs are 0, and bubble_cnt=0 on the cycle after rst drops.
- Pass-through, DEPTH=1: wb_in=2'b11, data_in={32'hDEAD_BEEF, 32'h0000_1234}, rd_in=5 → next cycle: reg_write=1, mem_to_reg=1, rd_out=5, data words match, out_valid=1.
- Zero-register gating: wb_in=2'b10, rd_in=0 → out_valid=1, reg_write=0, rd_out=0.
- Stall, DEPTH=3: stream items 1,2,3,4 with stall high for 2 cycles after item 2 enters → outputs appear in order 1,2,3,4 with exactly 2 extra cycles of latency, and no duplicates.
- Flush vs stall, DEPTH=3: pipeline full, then assert stall and flush together → next 3 cycles out_valid=0 and reg_write=0. bubble_cnt increments by 1 per cycle.
- Saturation, CNT_W=4: idle for 20 cycles after reset → bubble_cnt=15 and holds. Then rst → 0.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU datapath definitions: WB control bit positions and the
// default widths used by the MEM->WB pipeline register.
package cpu_pkg;

    // Bit positions inside the WB control field
    localparam int WB_REG_WRITE  = 1;
    localparam int WB_MEM_TO_REG = 0;

    // Default widths
    localparam int DATA_W_DEF   = 32;
    localparam int NUM_DATA_DEF = 2;
    localparam int REG_W_DEF    = 5;
    localparam int CTRL_W_DEF   = 2;
    localparam int DEPTH_DEF    = 1;
    localparam int CNT_W_DEF    = 16;

endpackage

// File: rtl/mem_wb_pipe_if.sv
// MEM->WB bus: control (stall/flush), the incoming item and the
// registered write-back outputs plus the bubble counter.
// master: memory-stage side, drives inputs and observes outputs.
// slave : the pipeline register itself.
interface mem_wb_pipe_if
    import cpu_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int NUM_DATA = NUM_DATA_DEF,
    parameter int REG_W    = REG_W_DEF,
    parameter int CTRL_W   = CTRL_W_DEF,
    parameter int CNT_W    = CNT_W_DEF
) ();

    logic                       stall;
    logic                       flush;
    logic                       in_valid;
    logic [CTRL_W-1:0]          wb_in;
    logic [NUM_DATA*DATA_W-1:0] data_in;
    logic [REG_W-1:0]           rd_in;

    logic                       out_valid;
    logic [CTRL_W-1:0]          ctrl_out;
    logic                       reg_write;
    logic                       mem_to_reg;
    logic [NUM_DATA*DATA_W-1:0] data_out;
    logic [REG_W-1:0]           rd_out;
    logic [CNT_W-1:0]           bubble_cnt;

    modport master (
        output stall, flush, in_valid, wb_in, data_in, rd_in,
        input  out_valid, ctrl_out, reg_write, mem_to_reg,
        input  data_out, rd_out, bubble_cnt
    );

    modport slave (
        input  stall, flush, in_valid, wb_in, data_in, rd_in,
        output out_valid, ctrl_out, reg_write, mem_to_reg,
        output data_out, rd_out, bubble_cnt
    );

endinterface

// File: rtl/wb_pipe_slice.sv
// One MEM->WB register slice: {valid, ctrl, data, rd}.
// Ports: clk, rst (sync, active-high), stall, flush, *_d next item, *_q held item.
module wb_pipe_slice #(
    parameter int CTRL_W = 2,
    parameter int DW     = 64,
    parameter int REG_W  = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              flush,
    input  logic              valid_d,
    input  logic [CTRL_W-1:0] ctrl_d,
    input  logic [DW-1:0]     data_d,
    input  logic [REG_W-1:0]  rd_d,
    output logic              valid_q,
    output logic [CTRL_W-1:0] ctrl_q,
    output logic [DW-1:0]     data_q,
    output logic [REG_W-1:0]  rd_q
);

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            ctrl_q  <= '0;
            data_q  <= '0;
            rd_q    <= '0;
        end else if (flush) begin
            // Bubble: only valid and ctrl matter, payload stays put
            valid_q <= 1'b0;
            ctrl_q  <= '0;
        end else if (!stall) begin
            valid_q <= valid_d;
            ctrl_q  <= ctrl_d;
            data_q  <= data_d;
            rd_q    <= rd_d;
        end
    end

endmodule

// File: rtl/mem_wb_pipe.sv
// MEM->WB pipeline register: DEPTH chained slices with stall/flush,
// capture-side gating of ctrl, and a saturating bubble counter.
// Ports: clk, rst (sync, active-high), bus (mem_wb_pipe_if.slave).
module mem_wb_pipe
    import cpu_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int NUM_DATA = NUM_DATA_DEF,
    parameter int REG_W    = REG_W_DEF,
    parameter int CTRL_W   = CTRL_W_DEF,
    parameter int DEPTH    = DEPTH_DEF,
    parameter int CNT_W    = CNT_W_DEF
) (
    input  logic          clk,
    input  logic          rst,
    mem_wb_pipe_if.slave  bus
);

    localparam int DW = NUM_DATA * DATA_W;

    logic              v [DEPTH+1];
    logic [CTRL_W-1:0] c [DEPTH+1];
    logic [DW-1:0]     d [DEPTH+1];
    logic [REG_W-1:0]  r [DEPTH+1];

    logic [CTRL_W-1:0] ctrl_gate;
    logic [CNT_W-1:0]  cnt;

    // A bubble carries no control; a write to x0 is never a write
    always_comb begin
        ctrl_gate = bus.in_valid ? bus.wb_in : '0;
        if (bus.rd_in == '0) begin
            ctrl_gate[WB_REG_WRITE] = 1'b0;
        end
    end

    assign v[0] = bus.in_valid;
    assign c[0] = ctrl_gate;
    assign d[0] = bus.data_in;
    assign r[0] = bus.rd_in;

    for (genvar i = 0; i < DEPTH; i++) begin : g_slice
        wb_pipe_slice #(
            .CTRL_W (CTRL_W),
            .DW     (DW),
            .REG_W  (REG_W)
        ) u_slice (
            .clk     (clk),
            .rst     (rst),
            .stall   (bus.stall),
            .flush   (bus.flush),
            .valid_d (v[i]),
            .ctrl_d  (c[i]),
            .data_d  (d[i]),
            .rd_d    (r[i]),
            .valid_q (v[i+1]),
            .ctrl_q  (c[i+1]),
            .data_q  (d[i+1]),
            .rd_q    (r[i+1])
        );
    end

    // Counts edges where the output held a bubble; sticks at all-ones
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (!v[DEPTH] && (cnt != '1)) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign bus.out_valid  = v[DEPTH];
    assign bus.ctrl_out   = c[DEPTH];
    assign bus.reg_write  = c[DEPTH][WB_REG_WRITE];
    assign bus.mem_to_reg = c[DEPTH][WB_MEM_TO_REG];
    assign bus.data_out   = d[DEPTH];
    assign bus.rd_out     = r[DEPTH];
    assign bus.bubble_cnt = cnt;

endmodule

// File: tb/tb_mem_wb_pipe.sv
// Self-checking bench for mem_wb_pipe: table-driven vectors on a DEPTH=1
// instance, hand sequences for stall/flush/saturation on a DEPTH=3, CNT_W=4 one.
module tb_mem_wb_pipe;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_a;
    logic rst_b;

    mem_wb_pipe_if #(
        .DATA_W(32), .NUM_DATA(2), .REG_W(5), .CTRL_W(2), .CNT_W(16)
    ) ifa ();

    mem_wb_pipe_if #(
        .DATA_W(32), .NUM_DATA(2), .REG_W(5), .CTRL_W(2), .CNT_W(4)
    ) ifb ();

    mem_wb_pipe #(
        .DATA_W(32), .NUM_DATA(2), .REG_W(5), .CTRL_W(2),
        .DEPTH(1), .CNT_W(16)
    ) dut_a (
        .clk (clk),
        .rst (rst_a),
        .bus (ifa)
    );

    mem_wb_pipe #(
        .DATA_W(32), .NUM_DATA(2), .REG_W(5), .CTRL_W(2),
        .DEPTH(3), .CNT_W(4)
    ) dut_b (
        .clk (clk),
        .rst (rst_b),
        .bus (ifb)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic        rst;
        logic        stall;
        logic        flush;
        logic        iv;
        logic [1:0]  wb;
        logic [63:0] data;
        logic [4:0]  rd;
        logic        ev;
        logic [1:0]  ec;
        logic [63:0] ed;
        logic [4:0]  er;
        logic [15:0] eb;
    } vec_t;

    function automatic vec_t mk(
        logic rst, logic stall, logic flush, logic iv, logic [1:0] wb,
        logic [63:0] data, logic [4:0] rd, logic ev, logic [1:0] ec,
        logic [63:0] ed, logic [4:0] er, logic [15:0] eb);
        vec_t t;
        t.rst = rst; t.stall = stall; t.flush = flush; t.iv = iv;
        t.wb = wb; t.data = data; t.rd = rd;
        t.ev = ev; t.ec = ec; t.ed = ed; t.er = er; t.eb = eb;
        return t;
    endfunction

    task automatic drv_b(input logic iv, input logic [4:0] rd,
                         input logic stall, input logic flush);
        ifb.in_valid = iv;
        ifb.wb_in    = 2'b10;
        ifb.rd_in    = rd;
        ifb.data_in  = {32'(rd) + 32'h100, 32'(rd)};
        ifb.stall    = stall;
        ifb.flush    = flush;
    endtask

    // reg_write must never appear without a valid, non-x0 destination
    always @(negedge clk) begin
        if (ifb.reg_write === 1'b1) begin
            check("invariant_b", {62'd0, ifb.out_valid, ifb.rd_out != 5'd0},
                  64'd3);
        end
    end

    vec_t vecs [11];

    // Stall sequence: per-edge inputs and expected outputs
    logic       s_iv  [9] = '{1, 1, 1, 1, 1, 1, 0, 0, 0};
    logic [4:0] s_rd  [9] = '{1, 2, 3, 3, 3, 4, 0, 0, 0};
    logic       s_st  [9] = '{0, 0, 1, 1, 0, 0, 0, 0, 0};
    logic       s_ev  [9] = '{0, 0, 0, 0, 1, 1, 1, 1, 0};
    logic [4:0] s_er  [9] = '{0, 0, 0, 0, 1, 2, 3, 4, 0};

    initial begin
        vecs[0]  = mk(1, 0, 0, 1, 2'b11, 64'hFFFF_FFFF_FFFF_FFFF, 5'd7,
                      0, 2'b00, 64'h0, 5'd0, 16'd0);
        vecs[1]  = mk(1, 0, 0, 1, 2'b11, 64'hFFFF_FFFF_FFFF_FFFF, 5'd7,
                      0, 2'b00, 64'h0, 5'd0, 16'd0);
        vecs[2]  = mk(0, 0, 0, 1, 2'b11, 64'hDEAD_BEEF_0000_1234, 5'd5,
                      1, 2'b11, 64'hDEAD_BEEF_0000_1234, 5'd5, 16'd1);
        vecs[3]  = mk(0, 0, 0, 1, 2'b10, 64'h0000_0022_0000_0011, 5'd0,
                      1, 2'b00, 64'h0000_0022_0000_0011, 5'd0, 16'd1);
        vecs[4]  = mk(0, 0, 0, 0, 2'b11, 64'hA, 5'd9,
                      0, 2'b00, 64'hA, 5'd9, 16'd1);
        vecs[5]  = mk(0, 0, 0, 1, 2'b10, 64'hB, 5'd31,
                      1, 2'b10, 64'hB, 5'd31, 16'd2);
        vecs[6]  = mk(0, 1, 0, 1, 2'b11, 64'hC, 5'd3,
                      1, 2'b10, 64'hB, 5'd31, 16'd2);
        vecs[7]  = mk(0, 0, 1, 1, 2'b11, 64'hD, 5'd4,
                      0, 2'b00, 64'hB, 5'd31, 16'd2);
        vecs[8]  = mk(0, 1, 1, 1, 2'b11, 64'hE, 5'd6,
                      0, 2'b00, 64'hB, 5'd31, 16'd3);
        vecs[9]  = mk(0, 0, 0, 1, 2'b01, 64'hF, 5'd0,
                      1, 2'b01, 64'hF, 5'd0, 16'd4);
        vecs[10] = mk(1, 0, 0, 1, 2'b11, 64'h1, 5'd8,
                      0, 2'b00, 64'h0, 5'd0, 16'd0);

        rst_a = 1'b1;
        rst_b = 1'b1;
        ifa.stall = 0; ifa.flush = 0; ifa.in_valid = 0;
        ifa.wb_in = 0; ifa.data_in = 0; ifa.rd_in = 0;
        drv_b(0, 5'd0, 0, 0);
        #1;

        // Table-driven, DEPTH=1
        for (int i = 0; i < 11; i++) begin
            rst_a         = vecs[i].rst;
            ifa.stall     = vecs[i].stall;
            ifa.flush     = vecs[i].flush;
            ifa.in_valid  = vecs[i].iv;
            ifa.wb_in     = vecs[i].wb;
            ifa.data_in   = vecs[i].data;
            ifa.rd_in     = vecs[i].rd;
            tick();
            check($sformatf("v%0d_valid", i), 64'(ifa.out_valid),
                  64'(vecs[i].ev));
            check($sformatf("v%0d_ctrl", i), 64'(ifa.ctrl_out),
                  64'(vecs[i].ec));
            check($sformatf("v%0d_regw", i), 64'(ifa.reg_write),
                  64'(vecs[i].ec[1]));
            check($sformatf("v%0d_m2r", i), 64'(ifa.mem_to_reg),
                  64'(vecs[i].ec[0]));
            check($sformatf("v%0d_data", i), ifa.data_out, vecs[i].ed);
            check($sformatf("v%0d_rd", i), 64'(ifa.rd_out),
                  64'(vecs[i].er));
            check($sformatf("v%0d_bub", i), 64'(ifa.bubble_cnt),
                  64'(vecs[i].eb));
        end

        // Flush + stall together, DEPTH=3
        rst_b = 1'b1;
        tick();
        tick();
        rst_b = 1'b0;
        drv_b(1, 5'd5, 0, 0);
        tick();
        drv_b(1, 5'd6, 0, 0);
        tick();
        drv_b(1, 5'd7, 0, 0);
        tick();
        check("fl_full_valid", 64'(ifb.out_valid), 64'd1);
        check("fl_full_rd", 64'(ifb.rd_out), 64'd5);
        check("fl_full_regw", 64'(ifb.reg_write), 64'd1);
        check("fl_full_bub", 64'(ifb.bubble_cnt), 64'd3);
        drv_b(0, 5'd0, 1, 1);
        for (int k = 0; k < 3; k++) begin
            tick();
            drv_b(0, 5'd0, 0, 0);
            check($sformatf("fl_%0d_valid", k), 64'(ifb.out_valid), 64'd0);
            check($sformatf("fl_%0d_regw", k), 64'(ifb.reg_write), 64'd0);
            check($sformatf("fl_%0d_bub", k), 64'(ifb.bubble_cnt),
                  64'(3 + k));
        end

        // Stall for 2 cycles after item 2 enters, DEPTH=3
        rst_b = 1'b1;
        tick();
        rst_b = 1'b0;
        for (int e = 0; e < 9; e++) begin
            drv_b(s_iv[e], s_rd[e], s_st[e], 0);
            tick();
            check($sformatf("st_e%0d_valid", e + 1), 64'(ifb.out_valid),
                  64'(s_ev[e]));
            if (s_ev[e]) begin
                check($sformatf("st_e%0d_rd", e + 1), 64'(ifb.rd_out),
                      64'(s_er[e]));
                check($sformatf("st_e%0d_data", e + 1), ifb.data_out,
                      {32'(s_er[e]) + 32'h100, 32'(s_er[e])});
            end
        end

        // Bubble counter saturation, CNT_W=4
        drv_b(0, 5'd0, 0, 0);
        rst_b = 1'b1;
        tick();
        rst_b = 1'b0;
        check("sat_start", 64'(ifb.bubble_cnt), 64'd0);
        for (int k = 1; k <= 20; k++) begin
            tick();
            check($sformatf("sat_k%0d", k), 64'(ifb.bubble_cnt),
                  64'((k > 15) ? 15 : k));
            if (k <= 3) begin
                check($sformatf("sat_idle%0d", k), 64'(ifb.out_valid), 64'd0);
            end
        end
        rst_b = 1'b1;
        tick();
        check("sat_rst", 64'(ifb.bubble_cnt), 64'd0);
        rst_b = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
